layer_sched: RTL and testbench

- Top-level layer sequencer for the accelerator.
- Walks a layer descriptor table in DRAM and dispatches each layer to the convolution engine or the pooling engine.
- Waits for the engine's done, then advances to the next layer. Only one engine runs at a time.
- Drives the DRAM-port select so top level can route the shared DRAM to the active engine.

---
 rtl/layer_sched_if.sv | 32 +++
 rtl/layer_sched.sv | 119 +++++++++++
 tb/tb_layer_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sched_if.sv
// Handshake bundle between the layer sequencer, the descriptor DRAM port and the two engines.
// The slave side is the sequencer; the master side is whoever drives it (top level or a bench).
interface layer_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dram_rdata;
    logic                  dram_rd_en;
    logic [ADDR_WIDTH-1:0] dram_addr;
    logic                  conv_enable;
    logic                  conv_done;
    logic                  pool_enable;
    logic                  pool_done;
    logic [1:0]            eng_sel;
    logic [2:0]            layer_idx;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  start, dram_rdata, conv_done, pool_done,
        output dram_rd_en, dram_addr, conv_enable, pool_enable,
               eng_sel, layer_idx, busy, done, err
    );

    modport master (
        output start, dram_rdata, conv_done, pool_done,
        input  dram_rd_en, dram_addr, conv_enable, pool_enable,
               eng_sel, layer_idx, busy, done, err
    );
endinterface

// File: rtl/layer_sched.sv
// Layer sequencer: fetches descriptors from DRAM, dispatches each to the conv or pool
// engine, waits for that engine's done under a watchdog, and reports completion or error.
module layer_sched #(
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   ADDR_WIDTH     = 18,
    parameter logic [ADDR_WIDTH-1:0] LAYER_TBL_BASE = 18'd32,
    parameter int                   MAX_LAYERS     = 8,
    parameter int                   TIMEOUT_WIDTH  = 20
) (
    input  logic         clk,
    input  logic         rst,
    layer_sched_if.slave bus
);
    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000001,
        S_FETCH    = 7'b0000010,
        S_CAPTURE  = 7'b0000100,
        S_DISPATCH = 7'b0001000,
        S_WAIT     = 7'b0010000,
        S_DONE     = 7'b0100000,
        S_ERR      = 7'b1000000
    } state_t;

    localparam logic [1:0] OP_CONV = 2'b00;
    localparam logic [1:0] OP_POOL = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;
    localparam logic [TIMEOUT_WIDTH-1:0] WD_ALL = '1;
    localparam logic [TIMEOUT_WIDTH-1:0] WD_PRE = WD_ALL - TIMEOUT_WIDTH'(1);
    localparam logic [2:0] IDX_LAST = 3'(MAX_LAYERS - 1);

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [2:0]               desc_q, desc_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     err_q, err_d;
    logic                     act_done;
    logic                     unused_rdata;

    assign unused_rdata = ^bus.dram_rdata[DATA_WIDTH-1:3];
    assign act_done     = (desc_q[1:0] == OP_CONV) ? bus.conv_done : bus.pool_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            desc_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                desc_d = bus.dram_rdata[2:0];
                case (bus.dram_rdata[1:0])
                    OP_END:  state_d = S_DONE;
                    OP_RSVD: state_d = S_ERR;
                    default: state_d = S_DISPATCH;
                endcase
            end
            S_DISPATCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = (wd_q == WD_ALL) ? wd_q : wd_q + TIMEOUT_WIDTH'(1);
                // An active done in the same cycle the watchdog saturates still counts.
                if (act_done) begin
                    if (desc_q[2])             state_d = S_DONE;
                    else if (idx_q == IDX_LAST) state_d = S_ERR;
                    else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_FETCH;
                    end
                end else if (wd_q >= WD_PRE) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.dram_rd_en  = (state_q == S_FETCH);
    assign bus.dram_addr   = (state_q == S_FETCH) ? LAYER_TBL_BASE + ADDR_WIDTH'(idx_q) : '0;
    assign bus.conv_enable = (state_q == S_DISPATCH) && (desc_q[1:0] == OP_CONV);
    assign bus.pool_enable = (state_q == S_DISPATCH) && (desc_q[1:0] == OP_POOL);
    assign bus.eng_sel     = (state_q == S_DISPATCH || state_q == S_WAIT) ?
                             ((desc_q[1:0] == OP_CONV) ? 2'b01 : 2'b10) : 2'b00;
    assign bus.layer_idx   = idx_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: plans each table run as a cycle timeline from the descriptor rules,
// drives engines/DRAM from that plan and compares every output on every cycle.
module tb_layer_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_sched_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) bus ();

    layer_sched #(
        .DATA_WIDTH(32), .ADDR_WIDTH(18), .LAYER_TBL_BASE(18'd32),
        .MAX_LAYERS(8), .TIMEOUT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Output vector layout: rd_en[28] addr[27:10] ce[9] pe[8] sel[7:6] idx[5:3] busy[2] done[1] err[0]
    logic [28:0] dut_vec;
    assign dut_vec = {bus.dram_rd_en, bus.dram_addr, bus.conv_enable, bus.pool_enable,
                      bus.eng_sel, bus.layer_idx, bus.busy, bus.done, bus.err};

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [8];
    logic [1:0]  t_op [8];
    logic        t_last [8];
    int          t_dly [8];

    logic [28:0] expv [256];
    logic [28:0] obs [256];
    logic        st [256];
    logic        cd [256];
    logic        pd [256];
    logic [1:0]  awt [256];
    int          L;
    int          m_idx = 0;
    int          m_err = 0;

    always @(posedge clk) begin
        if (bus.dram_rd_en) begin
            if (bus.dram_addr >= 18'd32 && bus.dram_addr <= 18'd39)
                bus.dram_rdata <= mem[bus.dram_addr[2:0]];
            else
                bus.dram_rdata <= 32'h0000_0002;
        end
    end

    function automatic logic [28:0] ev(int rd, int a, int ce, int pe, int sel,
                                       int idx, int bz, int dn, int er);
        logic [28:0] v;
        v = {rd[0], a[17:0], ce[0], pe[0], sel[1:0], idx[2:0], bz[0], dn[0], er[0]};
        return v;
    endfunction

    task automatic lit(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic set_tbl(input int i, input int op, input int last, input int dly);
        t_op[i]   = 2'(op);
        t_last[i] = last[0];
        t_dly[i]  = dly;
        mem[i]    = ($urandom() & 32'hFFFF_FFF8) | {29'd0, last[0], 2'(op)};
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 8; i++) set_tbl(i, 2, 0, 1);
    endtask

    task automatic rand_table();
        int n, kind;
        n    = $urandom_range(1, 8);
        kind = $urandom_range(0, 9);
        if (kind == 9) n = 8;
        for (int i = 0; i < 8; i++)
            set_tbl(i, $urandom_range(0, 1), 0,
                    ($urandom_range(0, 11) == 0) ? 16 : $urandom_range(1, 15));
        if (kind <= 5)      set_tbl(n-1, $urandom_range(0, 1), 1, $urandom_range(1, 15));
        else if (kind <= 7) set_tbl(n-1, 3, $urandom_range(0, 1), 1);
        else if (kind == 8) set_tbl(n-1, 2, 0, 1);
    endtask

    // Timeline of one run: FETCH, CAPTURE, DISPATCH, then d wait cycles with done on the last.
    task automatic build(input bit rnd);
        int c, k, idx, w, fin_c, e_f, sel, op;
        for (int i = 0; i < 256; i++) begin
            expv[i] = '0; st[i] = 0; cd[i] = 0; pd[i] = 0; awt[i] = 0;
        end
        st[0]   = 1;
        expv[0] = ev(0, 0, 0, 0, 0, m_idx, 0, 0, m_err);
        idx = 0; c = 1; fin_c = 0; e_f = 0;
        while (1) begin
            op = int'(t_op[idx]);
            expv[c]   = ev(1, 32 + idx, 0, 0, 0, idx, 1, 0, 0);
            expv[c+1] = ev(0, 0, 0, 0, 0, idx, 1, 0, 0);
            if (op == 3) begin
                expv[c+2] = ev(0, 0, 0, 0, 0, idx, 1, 1, 0); fin_c = c + 3; e_f = 0; break;
            end
            if (op == 2) begin
                expv[c+2] = ev(0, 0, 0, 0, 0, idx, 1, 0, 0); fin_c = c + 3; e_f = 1; break;
            end
            sel = (op == 0) ? 1 : 2;
            expv[c+2] = ev(0, 0, (op == 0) ? 1 : 0, (op == 1) ? 1 : 0, sel, idx, 1, 0, 0);
            w = (t_dly[idx] <= 15) ? t_dly[idx] : 15;
            for (int j = 0; j < w; j++) begin
                expv[c+3+j] = ev(0, 0, 0, 0, sel, idx, 1, 0, 0);
                awt[c+3+j]  = 2'(sel);
            end
            if (t_dly[idx] > 15) begin
                expv[c+18] = ev(0, 0, 0, 0, 0, idx, 1, 0, 0); fin_c = c + 19; e_f = 1; break;
            end
            k = c + 2 + t_dly[idx];
            if (sel == 1) cd[k] = 1; else pd[k] = 1;
            if (t_last[idx]) begin
                expv[k+1] = ev(0, 0, 0, 0, 0, idx, 1, 1, 0); fin_c = k + 2; e_f = 0; break;
            end
            if (idx == 7) begin
                expv[k+1] = ev(0, 0, 0, 0, 0, idx, 1, 0, 0); fin_c = k + 2; e_f = 1; break;
            end
            idx++;
            c = k + 1;
        end
        expv[fin_c] = ev(0, 0, 0, 0, 0, idx, 0, 0, e_f);
        L     = fin_c + 1;
        m_idx = idx;
        m_err = e_f;
        if (rnd) begin
            for (int i = 0; i < L; i++) begin
                if (awt[i] != 2'd1 && $urandom_range(0, 7) == 0) cd[i] = 1;
                if (awt[i] != 2'd2 && $urandom_range(0, 7) == 0) pd[i] = 1;
                if (i > 0 && i < L - 1 && $urandom_range(0, 5) == 0) st[i] = 1;
            end
        end
    endtask

    task automatic run(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            bus.start = st[c]; bus.conv_done = cd[c]; bus.pool_done = pd[c];
            @(negedge clk);
            obs[c] = dut_vec;
            tests++;
            if (dut_vec !== expv[c]) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h want %h", nm, c, dut_vec, expv[c]);
            end
        end
    endtask

    function automatic int cnt(int pos);
        int n = 0;
        for (int c = 0; c < L; c++) if (obs[c][pos]) n++;
        return n;
    endfunction

    initial begin
        int n, a;
        rst = 1'b1;
        bus.start = 0; bus.conv_done = 0; bus.pool_done = 0;
        clear_tbl();
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("reset_outputs", int'(dut_vec), 0);
        rst = 1'b0;

        // single conv layer, stray pool_done during its wait
        clear_tbl(); set_tbl(0, 0, 1, 7);
        build(0); pd[5] = 1; pd[7] = 1;
        run("t1", L);
        lit("t1_rd_c1", int'(obs[1][28]), 1);
        lit("t1_addr_c1", int'(obs[1][27:10]), 32);
        lit("t1_ce_c3", int'(obs[3][9]), 1);
        lit("t1_sel_c3", int'(obs[3][7:6]), 1);
        lit("t1_done_c11", int'(obs[11][1]), 1);
        lit("t1_sel_c11", int'(obs[11][7:6]), 0);
        lit("t1_busy_c12", int'(obs[12][2]), 0);

        // conv, pool, conv-last
        clear_tbl(); set_tbl(0, 0, 0, 4); set_tbl(1, 1, 0, 5); set_tbl(2, 0, 1, 3);
        build(0);
        run("t2", L);
        n = 0;
        for (int c = 0; c < L; c++) if (obs[c][28]) begin
            lit("t2_addr", int'(obs[c][27:10]), 32 + n); n++;
        end
        lit("t2_fetches", n, 3);
        n = 0;
        for (int c = 0; c < L; c++) if (obs[c][9] || obs[c][8]) begin
            lit("t2_sel", int'(obs[c][7:6]), (n == 1) ? 2 : 1); n++;
        end
        lit("t2_ce", cnt(9), 2);
        lit("t2_pe", cnt(8), 1);
        lit("t2_done", cnt(1), 1);
        lit("t2_idx", int'(obs[L-1][5:3]), 2);

        // empty table
        clear_tbl(); set_tbl(0, 3, 0, 1);
        build(0);
        run("t3", L);
        lit("t3_done_c3", int'(obs[3][1]), 1);
        lit("t3_enables", cnt(9) + cnt(8), 0);
        lit("t3_sel", cnt(7) + cnt(6), 0);

        // reserved op at index 1, then a restart clears err
        clear_tbl(); set_tbl(0, 0, 0, 3); set_tbl(1, 2, 0, 1);
        build(0);
        run("t4", L);
        lit("t4_err", int'(obs[L-1][0]), 1);
        lit("t4_busy", int'(obs[L-1][2]), 0);
        lit("t4_done", cnt(1), 0);
        lit("t4_ce", cnt(9), 1);
        clear_tbl(); set_tbl(0, 0, 1, 2);
        build(0);
        run("t5", L);
        lit("t5_err_c0", int'(obs[0][0]), 1);
        lit("t5_err_c1", int'(obs[1][0]), 0);

        // watchdog expiry with no conv_done
        clear_tbl(); set_tbl(0, 0, 1, 16);
        build(0);
        run("t6", L);
        lit("t6_err_c19", int'(obs[19][0]), 0);
        lit("t6_err_c20", int'(obs[20][0]), 1);
        n = 0;
        for (int c = 0; c < L; c++) if (obs[c][7:6] == 2'd1 && !obs[c][9]) n++;
        lit("t6_wait_cycles", n, 15);

        // done on the saturating cycle wins
        clear_tbl(); set_tbl(0, 1, 1, 15);
        build(0);
        run("t7", L);
        lit("t7_done", cnt(1), 1);
        lit("t7_err", int'(obs[L-1][0]), 0);

        // table overrun
        clear_tbl();
        for (int i = 0; i < 8; i++) set_tbl(i, 0, 0, 2);
        build(0);
        run("t8", L);
        n = 0; a = 0;
        for (int c = 0; c < L; c++) if (obs[c][28]) begin
            if (int'(obs[c][27:10]) != 32 + n) a++;
            n++;
        end
        lit("t8_fetches", n, 8);
        lit("t8_addr_bad", a, 0);
        lit("t8_err", int'(obs[L-1][0]), 1);
        lit("t8_idx", int'(obs[L-1][5:3]), 7);

        // reset in the middle of a wait
        clear_tbl(); set_tbl(0, 0, 1, 16);
        build(0);
        run("t9", 8);
        @(posedge clk); #1;
        bus.start = 0; bus.conv_done = 0; bus.pool_done = 0;
        rst = 1'b1;
        #1;
        lit("t9_reset_outputs", int'(dut_vec), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0; m_err = 0;

        for (int r = 0; r < 60; r++) begin
            rand_table();
            build(1);
            run("rand", L);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
